parallel_adder_pipe: RTL and testbench

// Parametrised, pipelined successor to the 3-bit parallel adder. Adds or subtracts two

---
 rtl/parallel_adder_pipe_if.sv | 22 ++
 rtl/parallel_adder_pipe.sv | 85 ++++++++
 tb/tb_parallel_adder_pipe.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/parallel_adder_pipe_if.sv
// parallel_adder_pipe_if: operand/result valid-ready bus of the pipelined adder.
interface parallel_adder_pipe_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;
    modport master (
        output in_valid, A, B, Cin, op, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );
    modport slave (
        input  in_valid, A, B, Cin, op, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );
endinterface

// File: rtl/parallel_adder_pipe.sv
// parallel_adder_pipe: add/subtract with the carry chain cut into STAGES registered slices.
module parallel_adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic                   clk,
    input logic                   rst,
    parallel_adder_pipe_if.slave  bus
);
    localparam int CH = WIDTH / STAGES;
    if (WIDTH < 1 || STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad
        $error("parallel_adder_pipe: WIDTH must be a positive multiple of STAGES");
    end
    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    assign b_eff   = bus.op ? ~bus.B : bus.B;
    assign c0      = bus.op ? ~bus.Cin : bus.Cin;
    assign advance = bus.in_ready;
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int HI = CH * (k + 1);
        // a_up/b_up: operand bits from slice k upward, still waiting for their stage
        logic [WIDTH-CH*k-1:0] a_up;
        logic [WIDTH-CH*k-1:0] b_up;
        logic [CH-1:0]         s_sl;
        logic                  c_in;
        logic                  c_out;
        logic                  v_in;
        logic [HI-1:0]         s_nx;
        logic                  v;
        logic                  c;
        logic [HI-1:0]         s;
        if (k == 0) begin : g_in
            assign a_up = bus.A;
            assign b_up = b_eff;
            assign c_in = c0;
            assign v_in = bus.in_valid;
            assign s_nx = s_sl;
        end else begin : g_in
            assign a_up = g_st[k-1].g_ab.a;
            assign b_up = g_st[k-1].g_ab.b;
            assign c_in = g_st[k-1].c;
            assign v_in = g_st[k-1].v;
            assign s_nx = {s_sl, g_st[k-1].s};
        end
        assign {c_out, s_sl} = {1'b0, a_up[CH-1:0]} + {1'b0, b_up[CH-1:0]} + {{CH{1'b0}}, c_in};
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v <= 1'b0;
                c <= 1'b0;
                s <= '0;
            end else if (advance) begin
                v <= v_in;
                c <= c_out;
                s <= s_nx;
            end
        end
        if (k < STAGES - 1) begin : g_ab
            logic [WIDTH-HI-1:0] a;
            logic [WIDTH-HI-1:0] b;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a <= '0;
                    b <= '0;
                end else if (advance) begin
                    a <= a_up[WIDTH-CH*k-1:CH];
                    b <= b_up[WIDTH-CH*k-1:CH];
                end
            end
        end
        if (k == STAGES - 1) begin : g_ov
            logic o;
            // carry into the MSB is recovered from the MSB's own sum bit
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) o <= 1'b0;
                else if (advance) o <= c_out ^ (a_up[CH-1] ^ b_up[CH-1] ^ s_sl[CH-1]);
            end
        end
    end
    assign bus.out_valid = g_st[STAGES-1].v;
    assign bus.Sum       = g_st[STAGES-1].s;
    assign bus.Cout      = g_st[STAGES-1].c;
    assign bus.Ovf       = g_st[STAGES-1].g_ov.o;
    assign bus.in_ready  = !bus.out_valid || bus.out_ready;
endmodule

// File: tb/tb_parallel_adder_pipe.sv
// tb_parallel_adder_pipe: directed and random checks of the 8/2 and 3/1 adder pipelines.
module tb_parallel_adder_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    parallel_adder_pipe_if #(.WIDTH(8)) b0();
    parallel_adder_pipe_if #(.WIDTH(3)) b1();
    parallel_adder_pipe #(.WIDTH(8), .STAGES(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    parallel_adder_pipe #(.WIDTH(3), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    typedef struct {int s; int co; int ov;} res_t;
    res_t q0[$];
    res_t q1[$];
    int checks = 0;
    int errors = 0;
    int n_out0 = 0;
    int issued;
    int base;
    logic acc;
    logic sent;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // reference: true integer/signed arithmetic, then reduce to WIDTH bits
    function automatic res_t model(input int w, input int a, input int b, input int ci, input int op);
        res_t r;
        int m = 1 << w;
        int h = m / 2;
        int sa = (a >= h) ? a - m : a;
        int sb = (b >= h) ? b - m : b;
        int raw = op != 0 ? a - b - ci : a + b + ci;
        int sr = op != 0 ? sa - sb - ci : sa + sb + ci;
        r.s  = (raw + 2 * m) % m;
        r.co = op != 0 ? int'(raw >= 0) : int'(raw >= m);
        r.ov = int'(sr < -h || sr >= h);
        return r;
    endfunction
    task automatic drive0(input logic iv, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic op, input logic ordy, output logic ac);
        @(negedge clk);
        b0.in_valid  = iv;
        b0.A         = a;
        b0.B         = b;
        b0.Cin       = ci;
        b0.op        = op;
        b0.out_ready = ordy;
        #1;
        ac = iv && b0.in_ready;
        if (b0.out_valid && ordy) begin
            if (q0.size() == 0) chk("d0_unexpected_out", b0.out_valid, 1'b0);
            else begin
                res_t e;
                e = q0.pop_front();
                n_out0++;
                chk("d0_sum", b0.Sum, e.s);
                chk("d0_cout", b0.Cout, e.co);
                chk("d0_ovf", b0.Ovf, e.ov);
            end
        end
        if (ac) q0.push_back(model(8, int'(a), int'(b), int'(ci), int'(op)));
    endtask
    task automatic drive1(input logic iv, input logic [2:0] a, input logic [2:0] b,
                          input logic ci, input logic op, input logic ordy, output logic ac);
        @(negedge clk);
        b1.in_valid  = iv;
        b1.A         = a;
        b1.B         = b;
        b1.Cin       = ci;
        b1.op        = op;
        b1.out_ready = ordy;
        #1;
        ac = iv && b1.in_ready;
        if (b1.out_valid && ordy) begin
            if (q1.size() == 0) chk("d1_unexpected_out", b1.out_valid, 1'b0);
            else begin
                res_t e;
                e = q1.pop_front();
                chk("d1_sum", b1.Sum, e.s);
                chk("d1_cout", b1.Cout, e.co);
                chk("d1_ovf", b1.Ovf, e.ov);
            end
        end
        if (ac) q1.push_back(model(3, int'(a), int'(b), int'(ci), int'(op)));
    endtask
    task automatic drain0;
        for (int n = 0; n < 20 && q0.size() > 0; n++) drive0(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1, acc);
        chk("d0_drain_empty", q0.size(), 0);
    endtask
    task automatic drain1;
        for (int n = 0; n < 20 && q1.size() > 0; n++) drive1(1'b0, 3'h0, 3'h0, 1'b0, 1'b0, 1'b1, acc);
        chk("d1_drain_empty", q1.size(), 0);
    endtask
    initial begin
        b0.in_valid = 1'b0; b0.A = '0; b0.B = '0; b0.Cin = 1'b0; b0.op = 1'b0; b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.A = '0; b1.B = '0; b1.Cin = 1'b0; b1.op = 1'b0; b1.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", b0.out_valid, 1'b0);
        chk("rst_sum", b0.Sum, 8'h00);
        chk("rst_cout", b0.Cout, 1'b0);
        chk("rst_ovf", b0.Ovf, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", b0.in_ready, 1'b1);
        // FF + 01 wraps to 00 with carry, two cycles after accept
        drive0(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, acc);
        chk("t1_accept", acc, 1'b1);
        drive0(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1, acc);
        chk("t1_lat1_valid", b0.out_valid, 1'b0);
        drive0(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1, acc);
        chk("t1_lat2_valid", b0.out_valid, 1'b1);
        chk("t1_sum", b0.Sum, 8'h00);
        chk("t1_cout", b0.Cout, 1'b1);
        chk("t1_ovf", b0.Ovf, 1'b0);
        drain0();
        drive0(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, acc);
        drive0(1'b1, 8'h10, 8'h20, 1'b0, 1'b1, 1'b1, acc);
        drive0(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1, acc);
        chk("t2_add_sum", b0.Sum, 8'h80);
        chk("t2_add_cout", b0.Cout, 1'b0);
        chk("t2_add_ovf", b0.Ovf, 1'b1);
        drive0(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1, acc);
        chk("t2_sub_sum", b0.Sum, 8'hF0);
        chk("t2_sub_cout", b0.Cout, 1'b0);
        chk("t2_sub_ovf", b0.Ovf, 1'b0);
        drain0();
        for (int i = 0; i < 10; i++) begin
            drive0(i < 8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
            if (i < 8) chk("t3_accept", acc, 1'b1);
            chk("t3_out_valid", b0.out_valid, i >= 2);
        end
        drain0();
        // three ops against a stalled consumer
        base = n_out0;
        drive0(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, acc);
        chk("t4_accept1", acc, 1'b1);
        drive0(1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, acc);
        chk("t4_accept2", acc, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, 8'h05, 8'h09, 1'b1, 1'b1, 1'b0, acc);
            chk("t4_in_ready", b0.in_ready, 1'b0);
            chk("t4_out_valid", b0.out_valid, 1'b1);
            chk("t4_sum_hold", b0.Sum, q0[0].s);
        end
        sent = 1'b0;
        for (int n = 0; n < 12 && (!sent || q0.size() > 0); n++) begin
            drive0(!sent, 8'h05, 8'h09, 1'b1, 1'b1, 1'b1, acc);
            if (acc) sent = 1'b1;
        end
        chk("t4_third_sent", sent, 1'b1);
        chk("t4_result_count", n_out0 - base, 3);
        drain0();
        drive0(1'b1, 8'hAA, 8'h11, 1'b0, 1'b0, 1'b1, acc);
        drive0(1'b1, 8'h55, 8'h22, 1'b1, 1'b1, 1'b1, acc);
        drive0(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0, acc);
        chk("t5_pre_valid", b0.out_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_valid", b0.out_valid, 1'b0);
        chk("t5_rst_sum", b0.Sum, 8'h00);
        chk("t5_rst_cout", b0.Cout, 1'b0);
        chk("t5_rst_ovf", b0.Ovf, 1'b0);
        q0.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive0(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1, acc);
            chk("t5_no_stale", b0.out_valid, 1'b0);
        end
        issued = 0;
        for (int n = 0; n < 6000 && issued < 1000; n++) begin
            drive0($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3) != 0, acc);
            if (acc) issued++;
        end
        chk("r0_issued", issued, 1000);
        drain0();
        drive1(1'b1, 3'b111, 3'b001, 1'b1, 1'b0, 1'b1, acc);
        chk("t6_accept", acc, 1'b1);
        drive1(1'b0, 3'h0, 3'h0, 1'b0, 1'b0, 1'b1, acc);
        chk("t6_valid", b1.out_valid, 1'b1);
        chk("t6_sum", b1.Sum, 3'b001);
        chk("t6_cout", b1.Cout, 1'b1);
        chk("t6_ovf", b1.Ovf, 1'b0);
        drain1();
        issued = 0;
        for (int n = 0; n < 6000 && issued < 1000; n++) begin
            drive1($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3) != 0, acc);
            if (acc) issued++;
        end
        chk("r1_issued", issued, 1000);
        drain1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
